// File: rtl/layer_compose_sequencer.sv
// ---------------------------------------------------------------------------
// layer_compose_sequencer
//
// Time-multiplexed layer compositor controller. For each accepted pixel
// request it walks the enabled layers in ascending order through one shared
// layer-pixel source (select + req/ack handshake). Layer 0 always loads the
// accumulator. Any higher layer overwrites it unless its pixel equals KEY.
// The composed pixel is then presented with a one-cycle valid pulse.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active-high
//   start_i      in   new-pixel request, accepted only while ready_o=1
//   ready_o      out  high in IDLE only
//   layer_en_i   in   per-layer enable, sampled at start (bit 0 ignored)
//   layer_sel_o  out  index of the layer being fetched
//   layer_req_o  out  fetch request to the layer source
//   layer_ack_i  in   source response strobe, layer_pix_i valid same cycle
//   layer_pix_i  in   pixel of layer layer_sel_o
//   RGB_o        out  composed pixel, held until the next completion
//   valid_o      out  one-cycle pulse when RGB_o carries a new result
// ---------------------------------------------------------------------------
module layer_compose_sequencer #(
   parameter int          N   = 8,
   parameter logic [23:0] KEY = 24'h000000,
   parameter int          SW  = $clog2(N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   output logic          ready_o,
   input  logic [N-1:0]  layer_en_i,
   output logic [SW-1:0] layer_sel_o,
   output logic          layer_req_o,
   input  logic          layer_ack_i,
   input  logic [23:0]   layer_pix_i,
   output logic [23:0]   RGB_o,
   output logic          valid_o
);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] sel, sel_nxt;
   logic [N-1:0]  en, en_nxt;
   logic [23:0]   acc, acc_nxt;
   logic [23:0]   rgb, rgb_nxt;

   // Smallest enabled layer strictly above the current one.
   logic [SW-1:0] next_sel;
   logic          more;

   always_comb begin
      more     = 1'b0;
      next_sel = '0;
      // Descending scan so the last hit is the smallest qualifying index.
      // Only indices below N are ever produced, whatever SW is.
      for (int j = N - 1; j >= 1; j--) begin
         if (en[j] && (j > int'(sel))) begin
            more     = 1'b1;
            next_sel = SW'(j);
         end
      end
   end

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state, datapath next values and outputs.
   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      sel_nxt     = sel;
      en_nxt      = en;
      acc_nxt     = acc;
      rgb_nxt     = rgb;
      ready_o     = 1'b0;
      layer_req_o = 1'b0;
      valid_o     = 1'b0;

      case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (start_i) begin
               en_nxt    = {layer_en_i[N-1:1], 1'b1};
               sel_nxt   = '0;
               state_nxt = FETCH;
            end
         end

         FETCH: begin
            layer_req_o = 1'b1;
            if (layer_ack_i) begin
               // Base layer loads unconditionally; upper layers only when opaque.
               if ((sel == '0) || (layer_pix_i != KEY)) acc_nxt = layer_pix_i;
               if (more) begin
                  sel_nxt = next_sel;
               end else begin
                  // Capture the final value now so RGB_o is valid in DONE.
                  rgb_nxt   = acc_nxt;
                  state_nxt = DONE;
               end
            end
         end

         DONE: begin
            valid_o   = 1'b1;
            sel_nxt   = '0;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sel <= '0;
         en  <= '0;
         acc <= '0;
         rgb <= '0;
      end else begin
         sel <= sel_nxt;
         en  <= en_nxt;
         acc <= acc_nxt;
         rgb <= rgb_nxt;
      end
   end

   assign layer_sel_o = sel;
   assign RGB_o       = rgb;

endmodule
